// File: rtl/adc_ddr_wr_arbiter.sv
// Round-robin arbiter sharing one AXI3 HP write port between four ADC capture buffers.
// One fixed-length INCR burst per grant, one outstanding transaction at a time.
module adc_ddr_wr_arbiter #(
  parameter int NCH       = 4,
  parameter int DW        = 64,
  parameter int AW        = 32,
  parameter int BURST_LEN = 16,
  parameter int AXI_ID    = 0
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic [NCH-1:0]      req_i,
  input  logic [NCH*AW-1:0]   addr_i,
  input  logic [NCH*DW-1:0]   dat_i,
  output logic [NCH-1:0]      rd_o,
  output logic [NCH-1:0]      gnt_o,
  output logic [NCH-1:0]      done_o,
  output logic [NCH-1:0]      err_o,
  output logic [5:0]          awid_o,
  output logic [AW-1:0]       awaddr_o,
  output logic [3:0]          awlen_o,
  output logic [2:0]          awsize_o,
  output logic [1:0]          awburst_o,
  output logic                awvalid_o,
  input  logic                awready_i,
  output logic [5:0]          wid_o,
  output logic [DW-1:0]       wdata_o,
  output logic [DW/8-1:0]     wstrb_o,
  output logic                wlast_o,
  output logic                wvalid_o,
  input  logic                wready_i,
  input  logic [1:0]          bresp_i,
  input  logic                bvalid_i,
  output logic                bready_o
);

  localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  state_t        state;
  logic [SW-1:0] ptr;
  logic [SW-1:0] sel;
  logic [SW-1:0] sel_nxt;
  logic          req_any;
  logic [CW-1:0] cnt;
  logic          aw_seen;
  logic          w_seen;
  logic          aw_hs;
  logic          w_hs;
  logic          last_hs;

  assign awid_o    = 6'(AXI_ID);
  assign wid_o     = 6'(AXI_ID);
  assign awlen_o   = 4'(BURST_LEN - 1);
  assign awsize_o  = 3'($clog2(DW / 8));
  assign awburst_o = 2'b01;
  assign wstrb_o   = '1;

  assign aw_hs   = awvalid_o & awready_i;
  assign w_hs    = wvalid_o & wready_i;
  assign wlast_o = wvalid_o & (cnt == CW'(BURST_LEN - 1));
  assign last_hs = w_hs & wlast_o;
  assign rd_o    = gnt_o & {NCH{w_hs}};
  // Head word is forced to zero outside the data phase so the bus is quiet when idle.
  assign wdata_o = wvalid_o ? dat_i[sel*DW +: DW] : '0;

  // First requester at or after ptr, wrapping modulo NCH.
  always_comb begin
    int unsigned idx;
    sel_nxt = '0;
    req_any = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      idx = (ptr + i) % NCH;
      if (!req_any && req_i[idx]) begin
        req_any = 1'b1;
        sel_nxt = idx[SW-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state     <= IDLE;
      ptr       <= '0;
      sel       <= '0;
      cnt       <= '0;
      aw_seen   <= 1'b0;
      w_seen    <= 1'b0;
      gnt_o     <= '0;
      done_o    <= '0;
      err_o     <= '0;
      awaddr_o  <= '0;
      awvalid_o <= 1'b0;
      wvalid_o  <= 1'b0;
      bready_o  <= 1'b0;
    end else begin
      done_o <= '0;
      err_o  <= '0;
      case (state)
        IDLE: begin
          if (req_any) begin
            state     <= XFER;
            sel       <= sel_nxt;
            gnt_o     <= {{(NCH-1){1'b0}}, 1'b1} << sel_nxt;
            awaddr_o  <= addr_i[sel_nxt*AW +: AW];
            awvalid_o <= 1'b1;
            wvalid_o  <= 1'b1;
            cnt       <= '0;
            aw_seen   <= 1'b0;
            w_seen    <= 1'b0;
            ptr       <= (sel_nxt == SW'(NCH - 1)) ? '0 : sel_nxt + 1'b1;
          end
        end
        XFER: begin
          if (aw_hs) begin
            awvalid_o <= 1'b0;
            aw_seen   <= 1'b1;
          end
          if (w_hs) begin
            cnt <= cnt + 1'b1;
          end
          if (last_hs) begin
            wvalid_o <= 1'b0;
            w_seen   <= 1'b1;
          end
          // AW and the last W beat may complete in either order or together.
          if ((aw_seen || aw_hs) && (w_seen || last_hs)) begin
            state    <= RESP;
            bready_o <= 1'b1;
          end
        end
        RESP: begin
          if (bvalid_i) begin
            state    <= IDLE;
            bready_o <= 1'b0;
            gnt_o    <= '0;
            done_o   <= gnt_o;
            err_o    <= (bresp_i != 2'b00) ? gnt_o : '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_ddr_wr_arbiter.sv
// Self-checking bench for adc_ddr_wr_arbiter: directed vector table, hand-written
// corner sequences and randomized transactions against a round-robin reference model.
module tb_adc_ddr_wr_arbiter;
  localparam int NCH = 4;
  localparam int DW  = 64;
  localparam int AW  = 32;
  localparam int BL  = 16;

  logic              clk = 1'b0;
  logic              rstn_i;
  logic [NCH-1:0]    req_i;
  logic [NCH*AW-1:0] addr_i;
  logic [NCH*DW-1:0] dat_i;
  logic [NCH-1:0]    rd_o, gnt_o, done_o, err_o;
  logic [5:0]        awid_o, wid_o;
  logic [AW-1:0]     awaddr_o;
  logic [3:0]        awlen_o;
  logic [2:0]        awsize_o;
  logic [1:0]        awburst_o;
  logic              awvalid_o, awready_i;
  logic [DW-1:0]     wdata_o;
  logic [DW/8-1:0]   wstrb_o;
  logic              wlast_o, wvalid_o, wready_i;
  logic [1:0]        bresp_i;
  logic              bvalid_i, bready_o;

  int unsigned widx[NCH];
  int unsigned exp_idx[NCH];
  int          ptr_model;
  int          nchecks = 0;
  int          nerrors = 0;

  always #5 clk = ~clk;

  adc_ddr_wr_arbiter #(.NCH(NCH), .DW(DW), .AW(AW), .BURST_LEN(BL), .AXI_ID(0)) dut (
    .clk_i(clk), .rstn_i(rstn_i), .req_i(req_i), .addr_i(addr_i), .dat_i(dat_i),
    .rd_o(rd_o), .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o),
    .awid_o(awid_o), .awaddr_o(awaddr_o), .awlen_o(awlen_o), .awsize_o(awsize_o),
    .awburst_o(awburst_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wid_o(wid_o), .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o),
    .wvalid_o(wvalid_o), .wready_i(wready_i),
    .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o)
  );

  function automatic logic [DW-1:0] mkword(input int ch, input int unsigned idx);
    return {24'hC0DE00, 8'(ch), idx};
  endfunction

  function automatic int rr_pick(input int p, input logic [NCH-1:0] m);
    for (int i = 0; i < NCH; i++)
      if (m[(p + i) % NCH]) return (p + i) % NCH;
    return -1;
  endfunction

  // FWFT requester model: head word advances on every pop strobe.
  always @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int k = 0; k < NCH; k++) widx[k] <= 0;
    end else begin
      for (int k = 0; k < NCH; k++) if (rd_o[k]) widx[k] <= widx[k] + 1;
    end
  end

  always_comb begin
    dat_i = '0;
    for (int k = 0; k < NCH; k++) dat_i[k*DW +: DW] = mkword(k, widx[k]);
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic rand_addrs();
    logic [AW-1:0] a;
    for (int k = 0; k < NCH; k++) begin
      a = AW'($urandom);
      a[6:0] = '0;
      addr_i[k*AW +: AW] = a;
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_gnt"}, gnt_o, 0);
    check({tag, "_rd"}, rd_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_err"}, err_o, 0);
    check({tag, "_awvalid"}, awvalid_o, 0);
    check({tag, "_wvalid"}, wvalid_o, 0);
    check({tag, "_wlast"}, wlast_o, 0);
    check({tag, "_bready"}, bready_o, 0);
    check({tag, "_awaddr"}, awaddr_o, 0);
    check({tag, "_wdata"}, wdata_o, 0);
    check({tag, "_const"}, {awid_o, wid_o, awlen_o, awsize_o, awburst_o, wstrb_o},
          {6'd0, 6'd0, 4'd15, 3'd3, 2'b01, 8'hFF});
  endtask

  task automatic do_reset();
    rstn_i = 1'b0; req_i = '0; awready_i = 0; wready_i = 0; bvalid_i = 0; bresp_i = 0;
    addr_i = '0;
    repeat (2) @(negedge clk);
    ptr_model = 0;
    for (int k = 0; k < NCH; k++) exp_idx[k] = 0;
    rstn_i = 1'b1;
  endtask

  // One complete transaction; awm/wm: 0 always ready, 1 random/toggle, 2 AW held until W done / random.
  task automatic run_txn(input logic [NCH-1:0] mask, input logic [AW-1:0] a_sel, input int awm,
                         input int wm, input logic [1:0] br, input int bdly, input logic hold,
                         input logic [NCH-1:0] exp_gnt, input logic [NCH-1:0] exp_err);
    int ch;
    int beats;
    int cyc;
    logic awd, wd, aw_now, w_now;
    ch = 0;
    for (int k = 0; k < NCH; k++) if (exp_gnt[k]) ch = k;
    @(negedge clk);
    rand_addrs();
    addr_i[ch*AW +: AW] = a_sel;
    req_i = mask; awready_i = 0; wready_i = 0; bvalid_i = 0;
    @(negedge clk); #1;
    check("gnt_latency", gnt_o, exp_gnt);
    if (gnt_o == '0) begin
      do_reset();
      return;
    end
    check("awaddr_latched", awaddr_o, a_sel);
    ptr_model = (ch + 1) % NCH;
    if (!hold) req_i = 4'($urandom);
    rand_addrs();
    beats = 0; cyc = 0; awd = 0; wd = 0;
    forever begin
      case (awm)
        0: awready_i = 1'b1;
        1: awready_i = 1'($urandom_range(0, 1));
        default: awready_i = wd;
      endcase
      case (wm)
        0: wready_i = 1'b1;
        1: wready_i = (cyc % 2 == 0);
        default: wready_i = 1'($urandom_range(0, 1));
      endcase
      #1;
      check("gnt_hold", gnt_o, exp_gnt);
      check("awvalid", awvalid_o, !awd);
      check("wvalid", wvalid_o, !wd);
      check("bready_xfer", bready_o, 0);
      aw_now = awvalid_o & awready_i;
      w_now  = 1'b0;
      if (wvalid_o && wready_i) begin
        check("rd_pulse", rd_o, exp_gnt);
        check("wdata", wdata_o, mkword(ch, exp_idx[ch] + beats));
        check("wlast", wlast_o, beats == BL - 1);
        beats++;
        w_now = (beats == BL);
      end else begin
        check("rd_idle", rd_o, 0);
      end
      if (aw_now) check("awaddr", awaddr_o, a_sel);
      awd = awd | aw_now;
      wd  = wd | w_now;
      if (awd && wd) break;
      cyc++;
      if (cyc > 200) begin
        check("xfer_timeout", 1, 0);
        do_reset();
        return;
      end
      @(negedge clk);
    end
    exp_idx[ch] += BL;
    @(negedge clk);
    awready_i = 0; wready_i = 0;
    for (int d = 0; d < bdly; d++) begin
      #1;
      check("bready_wait", bready_o, 1);
      check("done_early", done_o, 0);
      @(negedge clk);
    end
    bvalid_i = 1'b1; bresp_i = br;
    #1;
    check("bready", bready_o, 1);
    check("gnt_resp", gnt_o, exp_gnt);
    @(negedge clk);
    bvalid_i = 1'b0; bresp_i = 2'b00; req_i = '0;
    #1;
    check("done", done_o, exp_gnt);
    check("err", err_o, exp_err);
    check("gnt_release", gnt_o, 0);
    check("bready_release", bready_o, 0);
    @(negedge clk); #1;
    check("done_pulse", done_o, 0);
    check("err_pulse", err_o, 0);
  endtask

  typedef struct {
    logic [NCH-1:0] req;
    logic [AW-1:0]  addr;
    int             awm;
    int             wm;
    logic [1:0]     br;
    logic [NCH-1:0] exp_gnt;
    logic [NCH-1:0] exp_err;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int ord[$];
    int ch, beats, gap, cur;
    logic [NCH-1:0] prev_g, m, g, e;
    logic [1:0] br;
    logic [AW-1:0] a;

    tbl[0] = '{4'b0100, 32'h1000_0080, 0, 0, 2'b00, 4'b0100, 4'b0000};
    tbl[1] = '{4'b0010, 32'h2000_0100, 0, 0, 2'b10, 4'b0010, 4'b0010};
    tbl[2] = '{4'b1111, 32'h3000_0180, 0, 1, 2'b00, 4'b0100, 4'b0000};
    tbl[3] = '{4'b1111, 32'h4000_0200, 2, 0, 2'b00, 4'b1000, 4'b0000};
    tbl[4] = '{4'b1111, 32'h5000_0280, 0, 0, 2'b00, 4'b0001, 4'b0000};
    tbl[5] = '{4'b1001, 32'h6000_0300, 1, 2, 2'b00, 4'b1000, 4'b0000};
    tbl[6] = '{4'b0110, 32'h7000_0380, 0, 1, 2'b01, 4'b0010, 4'b0010};
    tbl[7] = '{4'b0011, 32'h8000_0400, 2, 1, 2'b00, 4'b0001, 4'b0000};
    tbl[8] = '{4'b1000, 32'h9000_0480, 0, 0, 2'b11, 4'b1000, 4'b1000};

    rstn_i = 1'b0; req_i = '0; addr_i = '0; awready_i = 0; wready_i = 0;
    bvalid_i = 0; bresp_i = 0;
    #2;
    check_quiet("reset");
    do_reset();
    #1;
    check_quiet("post_reset");

    for (int i = 0; i < 9; i++)
      run_txn(tbl[i].req, tbl[i].addr, tbl[i].awm, tbl[i].wm, tbl[i].br, 0, 1'b1,
              tbl[i].exp_gnt, tbl[i].exp_err);

    for (int n = 0; n < 40; n++) begin
      m  = 4'($urandom_range(1, 15));
      ch = rr_pick(ptr_model, m);
      g  = 4'(1) << ch;
      br = 2'($urandom_range(0, 3));
      e  = (br != 2'b00) ? g : 4'b0000;
      a  = AW'($urandom);
      a[6:0] = '0;
      run_txn(m, a, $urandom_range(0, 2), $urandom_range(0, 2), br, $urandom_range(0, 3),
              1'($urandom_range(0, 1)), g, e);
    end

    // All four requesting continuously from reset: expect 0,1,2,3,0,1 with idle gaps.
    rstn_i = 1'b0; req_i = 4'hF; awready_i = 0; wready_i = 0; bvalid_i = 0; bresp_i = 0;
    rand_addrs();
    for (int k = 0; k < NCH; k++) exp_idx[k] = 0;
    repeat (2) @(negedge clk);
    rstn_i = 1'b1;
    prev_g = '0; gap = 0; beats = 0; cur = 0;
    for (int cyc = 0; cyc <= 600; cyc++) begin
      if (cyc == 600) begin
        check("rr_timeout", 1, 0);
        break;
      end
      @(negedge clk);
      awready_i = 1'b1; wready_i = 1'b1; bvalid_i = bready_o; bresp_i = 2'b00;
      #1;
      if (gnt_o != '0 && prev_g == '0) begin
        for (int k = 0; k < NCH; k++) if (gnt_o[k]) cur = k;
        ord.push_back(cur);
        if (ord.size() > 1) check("rr_gap", gap >= 1, 1);
        check("rr_awaddr", awaddr_o, addr_i[cur*AW +: AW]);
        beats = 0;
      end
      if (gnt_o != '0 && wvalid_o && wready_i) begin
        check("rr_wdata", wdata_o, mkword(cur, exp_idx[cur] + beats));
        beats++;
      end
      if (gnt_o == '0 && prev_g != '0) begin
        check("rr_beats", beats, BL);
        check("rr_done", done_o, prev_g);
        exp_idx[cur] += BL;
        gap = 0;
        if (ord.size() == 6) break;
      end
      if (gnt_o == '0) gap++;
      prev_g = gnt_o;
    end
    check("rr_count", ord.size(), 6);
    for (int i = 0; i < ord.size() && i < 6; i++) check("rr_order", ord[i], i % NCH);

    // Reset in the middle of a burst; pointer must restart from channel 0.
    for (int t = 0; t < 2; t++) begin
      ch = (t == 0) ? 3 : 1;
      do_reset();
      @(negedge clk);
      rand_addrs();
      req_i = 4'(1) << ch; awready_i = 1'b1; wready_i = 1'b1;
      beats = 0;
      for (int w = 0; w < 10 && gnt_o == '0; w++) @(negedge clk);
      check("mid_gnt", gnt_o, 4'(1) << ch);
      repeat (7) @(negedge clk);
      #2;
      rstn_i = 1'b0;
      #1;
      check_quiet("mid_reset");
      @(negedge clk);
      #1;
      check("mid_no_done", done_o, 0);
      req_i = 4'b1001; awready_i = 0; wready_i = 0;
      for (int k = 0; k < NCH; k++) exp_idx[k] = 0;
      rstn_i = 1'b1;
      @(negedge clk); #1;
      check("gnt_after_reset", gnt_o, 4'b0001);
      check("done_after_reset", done_o, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
